// File: rtl/nr_divider_16_pkg.sv
// Shared definitions for the non-restoring divider: FSM state encoding and default width.
package nr_divider_16_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/nr_divider_16_addsub.sv
// Ripple add/sub cell shared with the Booth multiplier datapath.
// Subtraction uses inverted b with carry-in 1; the carry out of the top bit is discarded.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nr_addsub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s
);
    logic [N-1:0] b_eff;
    logic [N-1:0] carry;

    assign b_eff    = b ^ {N{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < N - 1; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    // Top bit needs only the sum; its carry out would be thrown away.
    assign s[N-1] = a[N-1] ^ b_eff[N-1] ^ carry[N-1];
endmodule

// File: rtl/nr_divider_16.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero is answered directly from IDLE.
module nr_divider_16
    import nr_divider_16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_next;

    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count;

    logic             do_load;
    logic             do_dz;
    logic             do_step;
    logic             do_fix;
    logic [WIDTH:0]   as_a;
    logic             as_sub;
    logic [WIDTH:0]   sum;

    nr_addsub #(.N(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   ({1'b0, d_reg}),
        .sub (as_sub),
        .s   (sum)
    );

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_dz      = 1'b0;
        do_step    = 1'b0;
        do_fix     = 1'b0;
        as_a       = a_reg;
        as_sub     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        do_load    = 1'b1;
                        state_next = ST_RUN;
                    end else begin
                        do_dz = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Shift {A,Q} left one place, then subtract D if A was non-negative, else add.
                do_step = 1'b1;
                as_a    = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
                as_sub  = ~a_reg[WIDTH];
                if (count == LAST) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                do_fix     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (do_load) begin
                a_reg <= '0;
                q_reg <= dividend;
                d_reg <= divisor;
                count <= '0;
                busy  <= 1'b1;
            end
            if (do_dz) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
            end
            if (do_step) begin
                a_reg <= sum;
                q_reg <= {q_reg[WIDTH-2:0], ~sum[WIDTH]};
                count <= count + 1'b1;
            end
            if (do_fix) begin
                // A negative partial remainder gets D added back once.
                if (a_reg[WIDTH]) begin
                    a_reg <= sum;
                end
                quotient    <= q_reg;
                remainder   <= a_reg[WIDTH] ? sum[WIDTH-1:0] : a_reg[WIDTH-1:0];
                div_by_zero <= 1'b0;
                done        <= 1'b1;
                busy        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nr_divider_16.sv
// Directed and random checks of nr_divider_16: results, latency, busy/done handshake, reset.
module tb_nr_divider_16;
    localparam int W         = 16;
    // Latencies are counted in clock edges after the edge that samples start.
    localparam int LAT_RUN   = 17;
    localparam int LAT_DZ    = 0;
    localparam int LAT_LIMIT = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    logic [2*W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    nr_divider_16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        step();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic wait_done(input int pre, output int lat);
        lat = pre;
        while (done !== 1'b1 && lat < LAT_LIMIT) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                          input int elat);
        int lat;
        accept(dvd, dvs);
        check({tag, "_busy"}, 32'(busy), 32'(!edz));
        wait_done(0, lat);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        logic saw_done;
        logic [W-1:0] dvd, dvs;
        logic [2*W-1:0] e;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic divisions and corner operands.
        run_op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, LAT_RUN);
        step();
        check("done_pulse", 32'(done), 32'd0);
        run_op("ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, LAT_RUN);
        run_op("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, LAT_RUN);
        run_op("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, LAT_RUN);
        run_op("d0_5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, LAT_RUN);

        // Divide by zero answered from IDLE without raising busy.
        step();
        run_op("dz1234", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, LAT_DZ);
        step();
        check("dz_done_pulse", 32'(done), 32'd0);
        check("dz_busy_after", 32'(busy), 32'd0);
        check("dz_dz_held", 32'(div_by_zero), 32'd1);

        // Start while busy is ignored; start on the done cycle is accepted.
        accept(16'd50000, 16'd3);
        repeat (4) step();
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd2;
        step();
        start = 1'b0;
        wait_done(5, lat);
        check("ign_lat", 32'(lat), 32'(LAT_RUN));
        check("ign_q", 32'(quotient), 32'd16666);
        check("ign_r", 32'(remainder), 32'd2);
        run_op("b2b_9_2", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, LAT_RUN);

        // Reset in the middle of a run clears everything and no done follows.
        accept(16'd1000, 16'd3);
        repeat (7) step();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_q", 32'(quotient), 32'd0);
        check("mid_rst_r", 32'(remainder), 32'd0);
        check("mid_rst_dz", 32'(div_by_zero), 32'd0);
        step();
        step();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("mid_rst_quiet", 32'(saw_done), 32'd0);
        run_op("d77_7", 16'd77, 16'd7, 16'd11, 16'd0, 1'b0, LAT_RUN);

        // Random operands: quotient/remainder from the bench's own division plus the invariant.
        for (int n = 0; n < 2000; n++) begin
            dvd = W'($urandom_range(0, 65535));
            if (n % 4 == 0) dvs = W'($urandom_range(1, 15));
            else            dvs = W'($urandom_range(1, 65535));
            exp_q.push_back({dvd / dvs, dvd % dvs});
            accept(dvd, dvs);
            wait_done(0, lat);
            check("rnd_lat", 32'(lat), 32'(LAT_RUN));
            e = exp_q.pop_front();
            check("rnd_q", 32'(quotient), 32'(e[2*W-1:W]));
            check("rnd_r", 32'(remainder), 32'(e[W-1:0]));
            check("rnd_inv", 32'(quotient) * 32'(dvs) + 32'(remainder), 32'(dvd));
            check("rnd_r_lt_d", 32'(remainder < dvs), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
